// File: rtl/shot_clock_counter.sv
// shot_clock_counter: 0..FULL_VALUE shot-clock seconds counter with run/stop, reloads and expiry buzzer
// Ports: clk, reset (sync, active-high); start_stop/reload_full/reload_short single-cycle pulses;
//        count (remaining seconds), running (RUN state), expired (EXPIRED state), buzzer (timed after expiry)
module shot_clock_counter #(
  parameter int TICK_DIV    = 50000000,
  parameter int FULL_VALUE  = 24,
  parameter int SHORT_VALUE = 14,
  parameter int BUZZ_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       reload_full,
  input  logic       reload_short,
  output logic [4:0] count,
  output logic       running,
  output logic       expired,
  output logic       buzzer
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int BW = BUZZ_CYCLES > 1 ? $clog2(BUZZ_CYCLES) : 1;
  typedef enum logic [1:0] {STOPPED, RUN, EXPIRED} state_t;
  state_t state_q, state_d;
  logic [4:0] count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] buzz_cnt_q, buzz_cnt_d;
  logic buzzer_q, buzzer_d;
  logic tick, load, ss_act;
  assign tick = state_q == RUN && presc_q == PW'(TICK_DIV - 1);
  // a non-loading reload_short still outranks start_stop in the same cycle
  assign load = reload_full || (reload_short && count_q < 5'(SHORT_VALUE));
  assign ss_act = start_stop && !reload_full && !reload_short;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    buzz_cnt_d = buzz_cnt_q;
    buzzer_d = buzzer_q;
    if (load) begin
      count_d = reload_full ? 5'(FULL_VALUE) : 5'(SHORT_VALUE);
      presc_d = '0;
      state_d = state_q == EXPIRED ? STOPPED : state_q;
      buzz_cnt_d = '0;
      buzzer_d = 1'b0;
    end else if (state_q == RUN) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      count_d = tick ? count_q - 5'd1 : count_q;
      state_d = tick && count_q == 5'd1 ? EXPIRED : ss_act ? STOPPED : RUN;
      buzzer_d = tick && count_q == 5'd1;
      buzz_cnt_d = '0;
    end else if (state_q == STOPPED) begin
      state_d = ss_act && count_q != 5'd0 ? RUN : STOPPED;
    end else begin
      // buzzer is high while the counter runs 0..BUZZ_CYCLES-1, then the counter freezes
      buzzer_d = buzzer_q && buzz_cnt_q != BW'(BUZZ_CYCLES - 1);
      buzz_cnt_d = buzzer_q ? buzz_cnt_q + BW'(1) : buzz_cnt_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STOPPED;
      count_q <= 5'(FULL_VALUE);
      presc_q <= '0;
      buzz_cnt_q <= '0;
      buzzer_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      buzz_cnt_q <= buzz_cnt_d;
      buzzer_q <= buzzer_d;
    end
  end
  assign count = count_q;
  assign running = state_q == RUN;
  assign expired = state_q == EXPIRED;
  assign buzzer = buzzer_q;
endmodule
